rx_envelope_detector: RTL and testbench
=======================================

Name: rx_envelope_detector

Overview:
Downstream of the receive band-pass filter. Consumes each filtered sample on its ready strobe and takes the absolute value with saturation. Keeps a moving average of magnitude over a 2^WIN_LOG2-sample window, which is the envelope. A hysteresis state machine on the envelope produces a signal-present flag and a rising-edge strobe for the correlator/acquisition logic.

Parameters:
DATA_W, 16, width of the input sample and the envelope output
WIN_LOG2, 5, log2 of the averaging window length (32 samples)
HOLD_SAMPLES, 4, consecutive below-high envelope updates in HOLD before returning to IDLE

Ports:
crx_clk  input  1  clock
rrx_rst  input  1  asynchronous reset, active-low
erx_en  input  1  enable; low causes a synchronous clear of all state
isample_valid  input  1  one-cycle strobe, filtered sample present (filter osample_ready)
isample  input  DATA_W signed  filtered sample
ithresh_hi  input  DATA_W unsigned  detection threshold
ithresh_lo  input  DATA_W unsigned  release threshold; ithresh_lo <= ithresh_hi is required of the integrator
oenv_valid  output  1  one-cycle strobe, new envelope value
oenvelope  output  DATA_W unsigned  window average of |sample|; MSB is always 0
owindow_full  output  1  window has received 2^WIN_LOG2 samples since clear
odetect  output  1  state is ACTIVE or HOLD
odetect_rise  output  1  one-cycle pulse on the IDLE->ACTIVE transition

Behaviour:
- Reset (rrx_rst=0, async): every output is 0. Window buffer, running sum, sample counter and hold counter are 0. FSM is IDLE.
- erx_en=0 at a clock edge: the same clear as reset, applied synchronously. Any in-flight pipeline data is discarded.
- Stage 1, edge after isample_valid:
  - abs register = |isample|.
  - -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1.
  - Result is DATA_W-1 bits unsigned.
  - The valid flag is registered alongside.
- Stage 2, next edge:
  - buf[wr_ptr] <= abs.
  - sum <= sum + abs - buf[wr_ptr], where buf[wr_ptr] is the old contents.
  - wr_ptr increments, wrapping from 2^WIN_LOG2-1 to 0.
  - oenvelope <= sum_next >> WIN_LOG2, zero-extended to DATA_W.
  - oenv_valid pulses.
- Latency: isample_valid at edge t gives oenv_valid high for the cycle after edge t+2.
- Fully pipelined: back-to-back isample_valid is accepted every cycle with no stalls and no lost samples.
- Sum width is DATA_W-1+WIN_LOG2 bits unsigned and can never overflow.
- Warm-up:
  - The window is pre-filled with zeros, so the envelope ramps during the first 2^WIN_LOG2 samples.
  - owindow_full sets on the stage-2 update of the 2^WIN_LOG2-th sample and stays set until reset or erx_en=0.
  - The sample counter saturates.
- FSM, evaluated only on stage-2 updates, using the new envelope value:
  - IDLE -> ACTIVE when env >= ithresh_hi and owindow_full (including the update that sets it). odetect_rise pulses on that same cycle.
  - ACTIVE -> HOLD when env < ithresh_lo. The hold counter is cleared.
  - HOLD -> ACTIVE when env >= ithresh_hi. The hold counter is cleared; no odetect_rise.
  - HOLD, env < ithresh_hi: the hold counter increments. On the HOLD_SAMPLES-th such update the FSM goes to IDLE.
  - Envelope values between lo and hi in ACTIVE: the FSM stays in ACTIVE.
- odetect is registered and is high in ACTIVE and HOLD.
- Threshold ports are sampled at each update and may change at any time.

Decomposition:
- Shared package rx_env_pkg holds:
  - FSM state encoding (IDLE=2'd0, ACTIVE=2'd1, HOLD=2'd2);
  - localparams for window depth (1<<WIN_LOG2) and sum width;
  - the saturation constant.
- One sub-module, rx_env_window:
  - circular magnitude buffer, write pointer, running sum, sample counter, owindow_full;
  - inputs: valid, abs, clear;
  - outputs: sum, update strobe.
- The top level holds the abs/saturate stage, the envelope register and the FSM.

Test Plan:
1. Assert reset mid-stream with valid samples in flight -> all outputs 0 immediately, with no clock needed. After release, the first valid sample 1000 gives oenvelope=31 at t+2.
2. 32 strobes of constant 1000, spaced 512 cycles apart -> envelopes 31, 62, 93, ..., 1000. owindow_full rises on the 32nd update.
3. 40 back-to-back strobes of -32768 -> final oenvelope=32767, no overflow. oenv_valid is high for 40 consecutive cycles.
4. Alternating +500/-500 for 64 samples -> oenvelope=500 from the 32nd update onward.
5. Set hi=800, lo=400, HOLD_SAMPLES=4:
   - Feed 32 samples of 1000 -> IDLE->ACTIVE on the 32nd update (oenvelope 1000), odetect_rise pulses once.
   - Then feed zeros -> HOLD on the first envelope below 400.
   - IDLE on the 4th update after that; odetect falls.
   - Resume 1000s while in HOLD -> return to ACTIVE without odetect_rise.
6. Drop erx_en for one cycle with the window full and in ACTIVE -> next cycle oenvelope=0, owindow_full=0, odetect=0. Re-enable: warm-up ramp restarts at 31.

Source files
------------

// File: rtl/rx_env_pkg.sv
// rx_env_pkg: state encoding and window sizing shared by the envelope detector.
package rx_env_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, HOLD = 2'd2} env_state_t;
  localparam int DATA_W_DEF    = 16;
  localparam int WIN_LOG2_DEF  = 5;
  localparam int WIN_DEPTH_DEF = 1 << WIN_LOG2_DEF;
  localparam int SUM_W_DEF     = DATA_W_DEF - 1 + WIN_LOG2_DEF;
  function automatic int win_depth(input int win_log2);
    return 1 << win_log2;
  endfunction
  function automatic int sum_w(input int data_w, input int win_log2);
    return data_w - 1 + win_log2;
  endfunction
  function automatic int sat_mag(input int data_w);
    return (1 << (data_w - 1)) - 1;
  endfunction
endpackage

// File: rtl/rx_env_window.sv
// rx_env_window: circular magnitude buffer with running sum and warm-up counter.
module rx_env_window
  import rx_env_pkg::*;
#(
  parameter int MAG_W    = 15,
  parameter int WIN_LOG2 = 5
) (
  input  logic                      crx_clk,
  input  logic                      rrx_rst,
  input  logic                      clear,
  input  logic                      valid,
  input  logic [MAG_W-1:0]          abs_mag,
  output logic                      upd,
  output logic [MAG_W+WIN_LOG2-1:0] sum_next,
  output logic                      full,
  output logic                      full_next
);
  localparam int DEPTH = win_depth(WIN_LOG2);
  localparam int SUM_W = MAG_W + WIN_LOG2;
  logic [MAG_W-1:0]    mag_buf [DEPTH];
  logic [WIN_LOG2-1:0] wr_ptr;
  logic [SUM_W-1:0]    sum;
  logic [WIN_LOG2:0]   cnt, cnt_next;
  // Modular arithmetic is exact: the true result always fits in SUM_W bits.
  assign sum_next  = valid ? sum + SUM_W'(abs_mag) - SUM_W'(mag_buf[wr_ptr]) : sum;
  assign cnt_next  = (valid && !full) ? cnt + 1'b1 : cnt;
  assign full      = cnt == (WIN_LOG2 + 1)'(DEPTH);
  assign full_next = cnt_next == (WIN_LOG2 + 1)'(DEPTH);
  assign upd       = valid;
  always_ff @(posedge crx_clk or negedge rrx_rst)
    if (!rrx_rst) begin
      for (int i = 0; i < DEPTH; i++) mag_buf[i] <= '0;
      wr_ptr <= '0;
      sum    <= '0;
      cnt    <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mag_buf[i] <= '0;
      wr_ptr <= '0;
      sum    <= '0;
      cnt    <= '0;
    end else if (valid) begin
      mag_buf[wr_ptr] <= abs_mag;
      wr_ptr          <= wr_ptr + 1'b1;
      sum             <= sum_next;
      cnt             <= cnt_next;
    end
endmodule

// File: rtl/rx_envelope_detector.sv
// rx_envelope_detector: |sample| moving-average envelope with hysteresis signal-present detection.
module rx_envelope_detector
  import rx_env_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int WIN_LOG2     = 5,
  parameter int HOLD_SAMPLES = 4
) (
  input  logic                     crx_clk,
  input  logic                     rrx_rst,
  input  logic                     erx_en,
  input  logic                     isample_valid,
  input  logic signed [DATA_W-1:0] isample,
  input  logic [DATA_W-1:0]        ithresh_hi,
  input  logic [DATA_W-1:0]        ithresh_lo,
  output logic                     oenv_valid,
  output logic [DATA_W-1:0]        oenvelope,
  output logic                     owindow_full,
  output logic                     odetect,
  output logic                     odetect_rise
);
  localparam int MAG_W  = DATA_W - 1;
  localparam int SUM_W  = sum_w(DATA_W, WIN_LOG2);
  localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);
  localparam logic [MAG_W-1:0] SAT = MAG_W'(sat_mag(DATA_W));
  logic               v1, upd, full_next;
  logic [MAG_W-1:0]   abs_q, abs_d;
  logic [DATA_W-1:0]  neg, env_next;
  logic [SUM_W-1:0]   sum_next;
  logic [HOLD_W-1:0]  hold_cnt;
  env_state_t         state;
  assign neg      = -isample;
  assign abs_d    = (isample[DATA_W-1] && isample[MAG_W-1:0] == '0) ? SAT
                  : isample[DATA_W-1] ? neg[MAG_W-1:0] : isample[MAG_W-1:0];
  assign env_next = DATA_W'(sum_next >> WIN_LOG2);
  rx_env_window #(.MAG_W(MAG_W), .WIN_LOG2(WIN_LOG2)) u_window (
    .crx_clk   (crx_clk),
    .rrx_rst   (rrx_rst),
    .clear     (!erx_en),
    .valid     (v1),
    .abs_mag   (abs_q),
    .upd       (upd),
    .sum_next  (sum_next),
    .full      (owindow_full),
    .full_next (full_next)
  );
  always_ff @(posedge crx_clk or negedge rrx_rst)
    if (!rrx_rst) begin
      v1           <= 1'b0;
      abs_q        <= '0;
      oenv_valid   <= 1'b0;
      oenvelope    <= '0;
      odetect      <= 1'b0;
      odetect_rise <= 1'b0;
      hold_cnt     <= '0;
      state        <= IDLE;
    end else if (!erx_en) begin
      v1           <= 1'b0;
      abs_q        <= '0;
      oenv_valid   <= 1'b0;
      oenvelope    <= '0;
      odetect      <= 1'b0;
      odetect_rise <= 1'b0;
      hold_cnt     <= '0;
      state        <= IDLE;
    end else begin
      v1           <= isample_valid;
      abs_q        <= abs_d;
      oenv_valid   <= upd;
      odetect_rise <= 1'b0;
      if (upd) begin
        oenvelope <= env_next;
        if (state == IDLE && env_next >= ithresh_hi && full_next) begin
          state        <= ACTIVE;
          odetect      <= 1'b1;
          odetect_rise <= 1'b1;
        end else if (state == ACTIVE && env_next < ithresh_lo) begin
          state    <= HOLD;
          hold_cnt <= '0;
        end else if (state == HOLD) begin
          if (env_next >= ithresh_hi) begin
            state    <= ACTIVE;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_W'(HOLD_SAMPLES - 1)) begin
            state    <= IDLE;
            odetect  <= 1'b0;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_rx_envelope_detector.sv
// tb_rx_envelope_detector: directed stimulus with a scoreboard-driven envelope monitor.
module tb_rx_envelope_detector;
  logic               crx_clk = 1'b0;
  logic               rrx_rst = 1'b1;
  logic               erx_en = 1'b1;
  logic               isample_valid = 1'b0;
  logic signed [15:0] isample = '0;
  logic [15:0]        ithresh_hi = 16'hFFFF;
  logic [15:0]        ithresh_lo = 16'h0000;
  logic               oenv_valid, owindow_full, odetect, odetect_rise;
  logic [15:0]        oenvelope;
  typedef struct {int env; bit full; bit det; bit rise; int due;} exp_t;
  exp_t sb[$];
  exp_t e;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  rx_envelope_detector #(.DATA_W(16), .WIN_LOG2(5), .HOLD_SAMPLES(4)) dut (
    .crx_clk      (crx_clk),
    .rrx_rst      (rrx_rst),
    .erx_en       (erx_en),
    .isample_valid(isample_valid),
    .isample      (isample),
    .ithresh_hi   (ithresh_hi),
    .ithresh_lo   (ithresh_lo),
    .oenv_valid   (oenv_valid),
    .oenvelope    (oenvelope),
    .owindow_full (owindow_full),
    .odetect      (odetect),
    .odetect_rise (odetect_rise)
  );
  always #5 crx_clk = ~crx_clk;
  always @(posedge crx_clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge crx_clk)
    if (oenv_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_env_valid", 1, 0);
      else begin
        e = sb.pop_front();
        chk("envelope", int'(oenvelope), e.env);
        chk("window_full", int'(owindow_full), int'(e.full));
        chk("detect", int'(odetect), int'(e.det));
        chk("detect_rise", int'(odetect_rise), int'(e.rise));
        chk("latency_cycle", cyc, e.due);
      end
    end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge crx_clk);
      #1;
    end
  endtask
  task automatic send(input int s, input int env, input bit full, input bit det, input bit rise,
                      input int gap, input bit push = 1'b1);
    isample       = 16'(s);
    isample_valid = 1'b1;
    if (push) sb.push_back('{env, full, det, rise, cyc + 2});
    @(posedge crx_clk);
    #1 isample_valid = 1'b0;
    idle(gap);
  endtask
  task automatic check_cleared(input string tag);
    chk({tag, "_envelope"}, int'(oenvelope), 0);
    chk({tag, "_env_valid"}, int'(oenv_valid), 0);
    chk({tag, "_window_full"}, int'(owindow_full), 0);
    chk({tag, "_detect"}, int'(odetect), 0);
    chk({tag, "_detect_rise"}, int'(odetect_rise), 0);
  endtask
  task automatic clear_en();
    erx_en = 1'b0;
    @(posedge crx_clk);
    #1 check_cleared("en_clear");
    erx_en = 1'b1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    #2 rrx_rst = 1'b0;
    #1 check_cleared("reset");
    idle(2);
    rrx_rst = 1'b1;
    idle(1);
    // mid-stream reset: samples 3 and 4 are still in the pipeline when reset hits
    send(1000, 31, 0, 0, 0, 0);
    send(1000, 62, 0, 0, 0, 0);
    send(1000, 0, 0, 0, 0, 0, 1'b0);
    send(1000, 0, 0, 0, 0, 0, 1'b0);
    rrx_rst = 1'b0;
    #1 check_cleared("midstream_reset");
    idle(2);
    rrx_rst = 1'b1;
    idle(1);
    send(1000, 31, 0, 0, 0, 4);
    clear_en();
    for (int k = 1; k <= 32; k++) send(1000, (1000 * k) >> 5, k == 32, 0, 0, 511);
    clear_en();
    for (int k = 1; k <= 40; k++) send(-32768, (32767 * (k > 32 ? 32 : k)) >> 5, k >= 32, 0, 0, 0);
    idle(5);
    clear_en();
    for (int k = 1; k <= 64; k++) send((k % 2) ? 500 : -500, (500 * (k > 32 ? 32 : k)) >> 5, k >= 32, 0, 0, 0);
    idle(5);
    ithresh_hi = 16'd800;
    ithresh_lo = 16'd400;
    clear_en();
    for (int k = 1; k <= 32; k++) send(1000, (1000 * k) >> 5, k == 32, k == 32, k == 32, 0);
    for (int j = 1; j <= 24; j++) send(0, (1000 * (32 - j)) >> 5, 1, j < 24, 0, 0);
    for (int m = 1; m <= 32; m++)
      send(1000, m <= 8 ? 250 : (8000 + 1000 * (m - 8)) >> 5, 1, m >= 26, m == 26, 0);
    idle(3);
    ithresh_hi = 16'd1001;
    ithresh_lo = 16'd1001;
    send(1000, 1000, 1, 1, 0, 3);
    send(1000, 1000, 1, 1, 0, 3);
    ithresh_hi = 16'd800;
    ithresh_lo = 16'd400;
    send(1000, 1000, 1, 1, 0, 3);
    ithresh_hi = 16'd1001;
    for (int k = 0; k < 5; k++) send(1000, 1000, 1, 1, 0, 3);
    ithresh_hi = 16'd800;
    clear_en();
    send(1000, 31, 0, 0, 0, 4);
    idle(5);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
